// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC capture controller.
// Holds the FSM state encoding and the default timing constants.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_DIV      = 4;
    localparam int DEF_PIPE_DLY = 8;
    localparam int DEF_ADC_BITS = 12;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_OTR_W    = 8;

    function automatic logic is_active(input state_e s);
        return (s == ST_PRIME) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Host-side handshake and capture bus of the ADC capture controller.
// The host drives start/stop/sample_count; the controller returns samples and status.
interface adc_capture_ctrl_if
    import adc_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int OTR_W    = DEF_OTR_W
) ();

    logic                start;
    logic                stop;
    logic [CNT_W-1:0]    sample_count;
    logic [ADC_BITS-1:0] sample_data;
    logic                sample_otr;
    logic                sample_valid;
    logic                busy;
    logic                done;
    logic [OTR_W-1:0]    otr_count;

    modport master (
        output start, stop, sample_count,
        input  sample_data, sample_otr, sample_valid, busy, done, otr_count
    );

    modport slave (
        input  start, stop, sample_count,
        output sample_data, sample_otr, sample_valid, busy, done, otr_count
    );

endinterface

// File: rtl/adc_clk_gen.sv
// ADC sample clock divider: half-period counter, toggling adc_clk, and a
// one-cycle strobe registered on each adc_clk rising transition.
module adc_clk_gen
    import adc_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic adc_clk,
    output logic rise_strobe
);

    localparam int HALF = DIV / 2;
    localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic            adc_clk_q, adc_clk_d;
    logic            rise_q, rise_d;

    // Next-state: hold everything cleared while disabled so the first rise lands DIV/2 cycles in.
    always_comb begin
        hc_d      = hc_q;
        adc_clk_d = adc_clk_q;
        rise_d    = 1'b0;
        if (!en) begin
            hc_d      = '0;
            adc_clk_d = 1'b0;
        end else if (hc_q == HC_LAST) begin
            hc_d      = '0;
            adc_clk_d = ~adc_clk_q;
            rise_d    = ~adc_clk_q;
        end else begin
            hc_d      = hc_q + HC_W'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q      <= '0;
            adc_clk_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            adc_clk_q <= adc_clk_d;
            rise_q    <= rise_d;
        end
    end

    assign adc_clk     = adc_clk_q;
    assign rise_strobe = rise_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC front-end controller: primes through the converter latency, then captures
// a finite burst or a continuous stream with OTR tagging and a saturating OTR count.
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int PIPE_DLY = DEF_PIPE_DLY,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int OTR_W    = DEF_OTR_W
) (
    input  logic                clk_PSRAM,
    input  logic                rst_n,
    input  logic [ADC_BITS-1:0] adc_out,
    input  logic                adc_OTR,
    output logic                adc_clk,
    adc_capture_ctrl_if.slave   bus
);

    localparam int PW = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;
    localparam logic [PW-1:0] PIPE_LAST = PW'(PIPE_DLY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [CNT_W-1:0]    samp_q, samp_d;
    logic [PW-1:0]       pipe_q, pipe_d;
    logic [ADC_BITS-1:0] data_q, data_d;
    logic                sotr_q, sotr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [OTR_W-1:0]    otrc_q, otrc_d;
    logic                rise_s;
    logic                clk_en_s;

    // Gate on both current and next state: the divider starts one cycle after
    // PRIME is entered and drops adc_clk on the very edge that leaves capture.
    assign clk_en_s = is_active(state_q) && is_active(state_d);

    adc_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk         (clk_PSRAM),
        .rst_n       (rst_n),
        .en          (clk_en_s),
        .adc_clk     (adc_clk),
        .rise_strobe (rise_s)
    );

    // Acquisition FSM, counters and capture registers (next-state).
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        samp_d   = samp_q;
        pipe_d   = pipe_q;
        data_d   = data_q;
        sotr_d   = sotr_q;
        otrc_d   = otrc_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    state_d  = ST_PRIME;
                    target_d = bus.sample_count;
                    samp_d   = '0;
                    pipe_d   = '0;
                    otrc_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (rise_s) begin
                    if (pipe_q == PIPE_LAST) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        pipe_d = pipe_q + PW'(1);
                    end
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_CAPTURE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (rise_s) begin
                    valid_d = 1'b1;
                    data_d  = adc_out;
                    sotr_d  = adc_OTR;
                    samp_d  = samp_q + CNT_W'(1);
                    if (adc_OTR && (otrc_q != {OTR_W{1'b1}})) begin
                        otrc_d = otrc_q + OTR_W'(1);
                    end else begin
                        otrc_d = otrc_q;
                    end
                    // target of zero means continuous: the counter wraps freely
                    if ((target_q != '0) && (samp_d == target_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = is_active(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            samp_q   <= '0;
            pipe_q   <= '0;
            data_q   <= '0;
            sotr_q   <= 1'b0;
            otrc_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            samp_q   <= samp_d;
            pipe_q   <= pipe_d;
            data_q   <= data_d;
            sotr_q   <= sotr_d;
            otrc_q   <= otrc_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.sample_data  = data_q;
    assign bus.sample_otr   = sotr_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.otr_count    = otrc_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomised bench for adc_capture_ctrl: four instances (default, OTR_W=2, DIV=2, DIV=8)
// checked cycle by cycle against an arithmetic timing model of the acquisition.
module tb_adc_capture_ctrl;

    localparam int PIPE = 8;
    localparam int DIVS [4] = '{4, 4, 2, 8};
    localparam int OTRW [4] = '{8, 2, 8, 8};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] adc_out;
    logic        adc_OTR;

    logic [3:0]  start_v;
    logic [3:0]  stop_v;
    logic [15:0] cnt_v [4];
    logic [3:0]  valid_o, done_o, busy_o, aclk_o, sotr_o;
    logic [11:0] data_o [4];
    logic [7:0]  otrc_o [4];

    logic [11:0] exp_data [4];
    logic        exp_sotr [4];
    int          exp_otrc [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        adc_capture_ctrl_if #(.CNT_W(16), .ADC_BITS(12), .OTR_W(OTRW[g])) bus ();

        assign bus.start        = start_v[g];
        assign bus.stop         = stop_v[g];
        assign bus.sample_count = cnt_v[g];
        assign valid_o[g]       = bus.sample_valid;
        assign done_o[g]        = bus.done;
        assign busy_o[g]        = bus.busy;
        assign sotr_o[g]        = bus.sample_otr;
        assign data_o[g]        = bus.sample_data;
        assign otrc_o[g]        = 8'(bus.otr_count);

        adc_capture_ctrl #(
            .DIV(DIVS[g]), .ADC_BITS(12), .PIPE_DLY(PIPE), .CNT_W(16), .OTR_W(OTRW[g])
        ) dut (
            .clk_PSRAM (clk),
            .rst_n     (rst_n),
            .adc_out   (adc_out),
            .adc_OTR   (adc_OTR),
            .adc_clk   (aclk_o[g]),
            .bus       (bus)
        );
    end

    // One acquisition, checked every cycle. Edge k=0 is the edge that samples start.
    task automatic test_run(input int sel, input int n, input int stop_k, input int restart_k,
                            input logic [31:0] otr_mask, input string nm);
        int dv, first, last, lim, j, omax;
        bit alive, strobe, e_busy, e_done, e_aclk;
        dv    = DIVS[sel];
        omax  = (1 << OTRW[sel]) - 1;
        first = dv / 2 + PIPE * dv + 1;
        last  = first + (n - 1) * dv;
        lim   = (n > 0) ? last + 3 : stop_k + 3;
        if (stop_k > 0 && stop_k + 3 < lim) lim = stop_k + 3;
        for (int k = 0; k <= lim; k++) begin
            alive  = (stop_k == 0) || (k < stop_k);
            strobe = alive && (k >= first) && (((k - first) % dv) == 0) && (n == 0 || k <= last);
            j      = strobe ? (k - first) / dv + 1 : 0;
            e_busy = alive && (n == 0 || k < last);
            e_done = alive && (n > 0) && (k == last);
            e_aclk = e_busy && (k >= dv / 2) && (((k - dv / 2) % dv) < dv / 2);
            @(negedge clk);
            start_v[sel] = (k == 0) || (k == restart_k);
            stop_v[sel]  = (stop_k > 0) && (k == stop_k);
            if (k == 0) cnt_v[sel] = 16'(n);
            else if (k == restart_k) cnt_v[sel] = 16'(n + 5);
            adc_out = 12'($urandom);
            adc_OTR = strobe ? ((j <= 32) ? otr_mask[j-1] : 1'b0) : 1'($urandom);
            @(posedge clk);
            #1;
            if (k == 0) exp_otrc[sel] = 0;
            if (strobe) begin
                exp_data[sel] = adc_out;
                exp_sotr[sel] = adc_OTR;
                if (adc_OTR && exp_otrc[sel] < omax) exp_otrc[sel]++;
            end
            tests += 6;
            if (valid_o[sel] !== strobe) begin
                fails++; $display("FAIL %s valid k=%0d got %b exp %b", nm, k, valid_o[sel], strobe);
            end
            if (done_o[sel] !== e_done) begin
                fails++; $display("FAIL %s done k=%0d got %b exp %b", nm, k, done_o[sel], e_done);
            end
            if (busy_o[sel] !== e_busy) begin
                fails++; $display("FAIL %s busy k=%0d got %b exp %b", nm, k, busy_o[sel], e_busy);
            end
            if (aclk_o[sel] !== e_aclk) begin
                fails++; $display("FAIL %s adc_clk k=%0d got %b exp %b", nm, k, aclk_o[sel], e_aclk);
            end
            if (data_o[sel] !== exp_data[sel] || sotr_o[sel] !== exp_sotr[sel]) begin
                fails++; $display("FAIL %s data k=%0d got %h/%b exp %h/%b", nm, k,
                                  data_o[sel], sotr_o[sel], exp_data[sel], exp_sotr[sel]);
            end
            if (otrc_o[sel] !== 8'(exp_otrc[sel])) begin
                fails++; $display("FAIL %s otr_count k=%0d got %0d exp %0d", nm, k, otrc_o[sel], exp_otrc[sel]);
            end
        end
        @(negedge clk);
        start_v[sel] = 1'b0;
        stop_v[sel]  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_v = '0;
        stop_v  = '0;
        adc_out = '0;
        adc_OTR = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cnt_v[s] = '0; exp_data[s] = '0; exp_sotr[s] = 1'b0; exp_otrc[s] = 0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            tests++;
            if ({valid_o[s], done_o[s], busy_o[s], aclk_o[s], sotr_o[s], data_o[s], otrc_o[s]} !== 25'd0) begin
                fails++; $display("FAIL reset dut%0d outputs got %b%b%b%b%b %h %h exp all zero", s,
                                  valid_o[s], done_o[s], busy_o[s], aclk_o[s], sotr_o[s], data_o[s], otrc_o[s]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_start_stop_idle();
        @(negedge clk);
        start_v[0] = 1'b1; stop_v[0] = 1'b1; cnt_v[0] = 16'd3;
        @(negedge clk);
        start_v[0] = 1'b0; stop_v[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tests++;
            if (busy_o[0] !== 1'b0 || aclk_o[0] !== 1'b0 || valid_o[0] !== 1'b0) begin
                fails++; $display("FAIL start_stop_idle k=%0d busy %b adc_clk %b valid %b exp 0 0 0",
                                  k, busy_o[0], aclk_o[0], valid_o[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start_v[0] = 1'b1; cnt_v[0] = 16'd0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (60) @(negedge clk);
        tests++;
        if (busy_o[0] !== 1'b1) begin
            fails++; $display("FAIL async_reset pre busy got %b exp 1", busy_o[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({valid_o[0], done_o[0], busy_o[0], aclk_o[0], sotr_o[0], data_o[0], otrc_o[0]} !== 25'd0) begin
            fails++; $display("FAIL async_reset outputs got %b%b%b%b%b %h %h exp all zero",
                              valid_o[0], done_o[0], busy_o[0], aclk_o[0], sotr_o[0], data_o[0], otrc_o[0]);
        end
        for (int s = 0; s < 4; s++) begin
            exp_data[s] = '0; exp_sotr[s] = 1'b0; exp_otrc[s] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_run(0, 3, 0, -1, $urandom, "after_reset");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run(0, 5, 0, -1, $urandom, "burst5");
        test_run(0, 0, 35 + 99 * 4 + 1, -1, $urandom, "continuous100");
        test_run(0, 10, 0, -1, 32'h0000_000C, "otr_3_4");
        test_run(1, 10, 0, -1, 32'h0000_03FF, "otr_saturate");
        test_run(1, 2, 0, -1, 32'h0, "otr_clear");
        test_start_stop_idle();
        test_run(0, 6, 0, 35 + 4, $urandom, "start_while_busy");
        test_run(0, 0, 35 + 2 * 4, -1, $urandom, "stop_on_strobe");
        test_run(0, 4, 7, -1, $urandom, "stop_in_prime");
        test_run(0, 1, 0, -1, $urandom, "back_to_back_a");
        test_run(0, 2, 0, -1, $urandom, "back_to_back_b");
        test_async_reset();
        test_run(2, 5, 0, -1, $urandom, "div2_burst5");
        test_run(3, 5, 0, -1, $urandom, "div8_burst5");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
